// File: rtl/temp_sensor_pkg.sv
// Shared constants and state encoding for the MAX6630 read master.
// Frame layout: temperature in the MSBs, status flag at bit 2.
package temp_sensor_pkg;

  localparam int C_TEMP_SENSOR_PO_WL   = 16;
  localparam int C_TEMP_SENSOR_DATA_WL = 13;
  localparam int C_STATUS_BIT          = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE,
    GAP
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs.
// Both flops clear on the asynchronous active-high reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/temp_sensor_reader.sv
// SPI-style read master for the MAX6630: 16 SCK pulses per frame,
// MSB-first capture, 13-bit temperature plus status-bit check.
module temp_sensor_reader
  import temp_sensor_pkg::*;
#(
  parameter int C_SCK_HALF     = 8,
  parameter int C_CS_SETUP_CYC = 4,
  parameter int C_CS_HIGH_CYC  = 8
) (
  input  logic Clk_IN,
  input  logic Reset_IN,
  input  logic Start_IN,
  input  logic Temp_sensor_SO_IN,
  output logic Temp_sensor_SCK_OUT,
  output logic Temp_sensor_CS_OUT,
  output logic [C_TEMP_SENSOR_DATA_WL-1:0] Temp_Data_OUT,
  output logic Data_valid_OUT,
  output logic Frame_error_OUT,
  output logic Busy_OUT
);

  localparam int CNT_MAX_A =
    (C_SCK_HALF > C_CS_SETUP_CYC) ? C_SCK_HALF : C_CS_SETUP_CYC;
  localparam int CNT_MAX =
    (CNT_MAX_A > C_CS_HIGH_CYC) ? CNT_MAX_A : C_CS_HIGH_CYC;
  localparam int CNT_W = $clog2(CNT_MAX);
  localparam int BIT_W = $clog2(C_TEMP_SENSOR_PO_WL);

  localparam logic [CNT_W-1:0] SETUP_LAST =
    CNT_W'(C_CS_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST =
    CNT_W'(C_SCK_HALF - 1);
  // DONE plus the IDLE sampling cycle also count as CS-high time
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(C_CS_HIGH_CYC - 3);
  localparam logic [BIT_W-1:0] BIT_LAST =
    BIT_W'(C_TEMP_SENSOR_PO_WL - 1);

  state_t                           state;
  logic [CNT_W-1:0]                 cnt;
  logic [BIT_W-1:0]                 bit_cnt;
  logic [C_TEMP_SENSOR_PO_WL-1:0]   shift;
  logic                             so_s;
  logic                             sck;
  logic                             cs_n;
  logic                             busy;
  logic                             valid;
  logic                             ferr;
  logic [C_TEMP_SENSOR_DATA_WL-1:0] data;

  sync_2ff #(.W(1)) u_so_sync (
    .clk (Clk_IN),
    .rst (Reset_IN),
    .d   (Temp_sensor_SO_IN),
    .q   (so_s)
  );

  always_ff @(posedge Clk_IN or posedge Reset_IN) begin
    if (Reset_IN) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      sck     <= 1'b0;
      cs_n    <= 1'b1;
      busy    <= 1'b0;
      valid   <= 1'b0;
      ferr    <= 1'b0;
      data    <= '0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start_IN) begin
            state   <= SETUP;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            state <= SHIFT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            sck <= ~sck;
            // the edge that drops SCK captures the bit
            if (sck) begin
              shift   <= {shift[C_TEMP_SENSOR_PO_WL-2:0], so_s};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) begin
                state <= DONE;
                cs_n  <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          data  <= shift[C_TEMP_SENSOR_PO_WL-1 -: C_TEMP_SENSOR_DATA_WL];
          ferr  <= shift[C_STATUS_BIT];
          valid <= 1'b1;
          state <= GAP;
          cnt   <= '0;
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Temp_sensor_SCK_OUT = sck;
  assign Temp_sensor_CS_OUT  = cs_n;
  assign Temp_Data_OUT       = data;
  assign Data_valid_OUT      = valid;
  assign Frame_error_OUT     = ferr;
  assign Busy_OUT            = busy;

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Bench for temp_sensor_reader: behavioural MAX6630 model driving SO,
// frame-level expectations derived from the frame contents.
module tb_temp_sensor_reader;

  localparam int HALF  = 8;
  localparam int SETUP = 4;
  localparam int HIGH  = 8;
  localparam int BITS  = 16;
  localparam int LAT   = 1 + SETUP + 2 * BITS * HALF;
  localparam int CSLOW = SETUP + 2 * BITS * HALF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        so;
  logic        sck;
  logic        cs;
  logic [12:0] data;
  logic        valid;
  logic        ferr;
  logic        busy;

  int total = 0;
  int bad = 0;

  temp_sensor_reader dut (
    .Clk_IN              (clk),
    .Reset_IN            (rst),
    .Start_IN            (start),
    .Temp_sensor_SO_IN   (so),
    .Temp_sensor_SCK_OUT (sck),
    .Temp_sensor_CS_OUT  (cs),
    .Temp_Data_OUT       (data),
    .Data_valid_OUT      (valid),
    .Frame_error_OUT     (ferr),
    .Busy_OUT            (busy)
  );

  always #5 clk = ~clk;

  // sensor: MSB out while CS idles, next bit after every SCK fall
  logic [15:0] sensor_frame = 16'h0000;
  int idx = 15;
  always @(negedge sck or posedge cs) begin
    if (cs) idx = 15;
    else idx = idx - 1;
  end
  assign so = (idx >= 0 && idx < 16) ? sensor_frame[idx[3:0]] : 1'b0;

  int rises = 0;
  int falls = 0;
  int valids = 0;
  int low_run = 0;
  int hi_run = 0;
  int last_low = 0;
  int gap_len[256];
  logic sck_q = 1'b0;
  logic cs_q = 1'b1;

  always @(negedge clk) begin
    if (sck === 1'b1 && sck_q === 1'b0) rises++;
    if (valid === 1'b1) valids++;
    if (cs === 1'b0) begin
      if (cs_q === 1'b1) begin
        gap_len[falls % 256] = hi_run;
        falls++;
        low_run = 0;
      end
      low_run++;
    end else begin
      if (cs_q === 1'b0) begin
        last_low = low_run;
        hi_run = 0;
      end
      hi_run++;
    end
    sck_q = sck;
    cs_q = cs;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  // expected outputs held by the model between frames
  logic [12:0] m_data = 13'h0;
  logic        m_err = 1'b0;

  task automatic run_frame(input logic [15:0] f, input string tag);
    int r0, v0, cyc;
    bit hold_ok;
    logic [12:0] ed;
    logic ee;
    ed = f[15:3];
    ee = f[2];
    sensor_frame = f;
    r0 = rises;
    v0 = valids;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    hold_ok = 1'b1;
    while (valid !== 1'b1 && cyc < 2000) begin
      if (data !== m_data || ferr !== m_err) hold_ok = 1'b0;
      tick();
      cyc++;
    end
    check({tag, "_lat"}, cyc, LAT);
    check({tag, "_data"}, {19'd0, data}, {19'd0, ed});
    check({tag, "_err"}, {31'd0, ferr}, {31'd0, ee});
    check({tag, "_hold"}, {31'd0, hold_ok}, 32'd1);
    tick();
    check({tag, "_strobe"}, {31'd0, valid}, 32'd0);
    check({tag, "_nvalid"}, valids - v0, 1);
    check({tag, "_rises"}, rises - r0, BITS);
    check({tag, "_cslow"}, last_low, CSLOW);
    m_data = ed;
    m_err = ee;
    wait_idle(tag);
  endtask

  initial begin
    int f0, v0, r0, n;
    repeat (3) tick();
    check("rst_cs", {31'd0, cs}, 32'd1);
    check("rst_sck", {31'd0, sck}, 32'd0);
    check("rst_data", {19'd0, data}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_err", {31'd0, ferr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (3) tick();

    run_frame({13'h0190, 3'b000}, "pos25");
    run_frame({13'h1FF0, 3'b011}, "neg");
    run_frame({13'h0ABC, 3'b110}, "ferr");
    run_frame({13'h0190, 3'b001}, "clean");

    // second Start while busy must be dropped
    f0 = falls;
    v0 = valids;
    sensor_frame = {13'h0321, 3'b000};
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (39) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("busy");
    repeat (20) tick();
    check("busy_falls", falls - f0, 1);
    check("busy_valids", valids - v0, 1);
    check("busy_data", {19'd0, data}, 32'h0321);
    m_data = 13'h0321;
    m_err = 1'b0;

    // reset in the middle of a frame
    sensor_frame = {13'h1555, 3'b100};
    r0 = rises;
    v0 = valids;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (rises - r0 < 5 && n < 2000) begin
      tick();
      n++;
    end
    check("mid_rises", rises - r0, 5);
    rst = 1'b1;
    #1;
    check("mid_cs", {31'd0, cs}, 32'd1);
    check("mid_sck", {31'd0, sck}, 32'd0);
    check("mid_data", {19'd0, data}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    m_data = 13'h0;
    m_err = 1'b0;
    repeat (400) tick();
    check("mid_novalid", valids - v0, 0);
    run_frame({13'h0190, 3'b000}, "after_rst");

    // Start held high: back-to-back frames
    f0 = falls;
    v0 = valids;
    r0 = rises;
    sensor_frame = {13'h07F3, 3'b010};
    start = 1'b1;
    n = 0;
    while (valids - v0 < 3 && n < 3000) begin
      tick();
      n++;
    end
    start = 1'b0;
    wait_idle("cont");
    repeat (20) tick();
    check("cont_valids", valids - v0, 3);
    check("cont_falls", falls - f0, 3);
    check("cont_rises", rises - r0, 3 * BITS);
    check("cont_gap1", gap_len[(f0 + 1) % 256], HIGH);
    check("cont_gap2", gap_len[(f0 + 2) % 256], HIGH);
    check("cont_data", {19'd0, data}, 32'h07F3);
    m_data = 13'h07F3;
    m_err = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_frame(16'($urandom), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
